// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulate stage.
package mac_pkg;

    localparam int PROD_W = 6;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

    // term_cnt must be able to hold the value N_TERMS itself
    function automatic int cnt_w(input int n_terms);
        return $clog2(n_terms + 1);
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / result-out handshake bundle of the accumulate stage.
interface mac_accumulator_if #(
    parameter int PROD_W = mac_pkg::PROD_W,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              sat;
    logic [CNT_W-1:0]  term_cnt;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, acc_out, sat, term_cnt
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, acc_out, sat, term_cnt
    );
endinterface

// File: rtl/mac_sat_adder.sv
// Unsigned saturating add of a product onto the running sum.
module mac_sat_adder #(
    parameter int A_W = 12,
    parameter int B_W = 6
) (
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    output logic [A_W-1:0] sum_o,
    output logic           ovf_o
);
    logic [A_W:0] sum_ext;

    // One extra bit: its carry-out is the saturation select.
    assign sum_ext = {1'b0, a_i} + (A_W + 1)'(b_i);
    assign ovf_o   = sum_ext[A_W];
    assign sum_o   = ovf_o ? '1 : sum_ext[A_W-1:0];
endmodule

// File: rtl/mac_accumulator.sv
// Accumulate stage: sums up to N_TERMS products, then holds the result
// until the consumer takes it.
module mac_accumulator #(
    parameter int PROD_W  = mac_pkg::PROD_W,
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    mac_accumulator_if.slave   bus
);
    import mac_pkg::*;

    localparam int CNT_W = cnt_w(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vld_q, vld_d;

    logic [ACC_W-1:0]   sum;
    logic               ovf;
    logic               accept;
    logic               final_beat;

    mac_sat_adder #(.A_W(ACC_W), .B_W(PROD_W)) u_add (
        .a_i   (acc_q),
        .b_i   (bus.in_prod),
        .sum_o (sum),
        .ovf_o (ovf)
    );

    assign bus.in_ready = (state_q == ACC);
    assign accept       = bus.in_valid & bus.in_ready;
    // Covers in_last on the N_TERMS-th beat with a single transition.
    assign final_beat   = bus.in_last | (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        if (clr) begin
            state_d = ACC;
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        acc_d = sum;
                        sat_d = sat_q | ovf;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (final_beat) begin
                            state_d = DONE;
                            vld_d   = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                        sat_d   = 1'b0;
                        cnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACC;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.acc_out   = acc_q;
    assign bus.sat       = sat_q;
    assign bus.term_cnt  = cnt_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench: two lockstep DUTs (ACC_W 12 and 8) fed the same beats.
module tb_mac_accumulator;
    localparam int N = 8;
    localparam int WA = 12;
    localparam int WB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d_clr = 1'b0, d_valid = 1'b0, d_last = 1'b0, d_ordy = 1'b0;
    logic [5:0] d_prod = '0;

    always #5 clk = ~clk;

    mac_accumulator_if #(.PROD_W(6), .ACC_W(WA), .CNT_W(4)) ifa ();
    mac_accumulator_if #(.PROD_W(6), .ACC_W(WB), .CNT_W(4)) ifb ();

    assign ifa.in_valid = d_valid;  assign ifb.in_valid = d_valid;
    assign ifa.in_prod  = d_prod;   assign ifb.in_prod  = d_prod;
    assign ifa.in_last  = d_last;   assign ifb.in_last  = d_last;
    assign ifa.out_ready = d_ordy;  assign ifb.out_ready = d_ordy;

    mac_accumulator #(.PROD_W(6), .ACC_W(WA), .N_TERMS(N)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(d_clr), .bus(ifa));
    mac_accumulator #(.PROD_W(6), .ACC_W(WB), .N_TERMS(N)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(d_clr), .bus(ifb));

    typedef struct { int total; int cnt; } exp_t;
    exp_t q[$];

    // Reference: unbounded integer sum of the group; saturation is just a clip.
    int  part = 0, cnt = 0;
    bit  busy = 0;
    int  n_err = 0, n_chk = 0;

    function automatic int clip(input int t, input int w);
        int mx = (1 << w) - 1;
        return (t > mx) ? mx : t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (d_clr) begin
            busy = 0; part = 0; cnt = 0;
        end else if (busy) begin
            if (d_ordy) busy = 0;
        end else if (d_valid) begin
            part += int'(d_prod);
            cnt++;
            if (d_last || cnt == N) begin
                q.push_back('{total: part, cnt: cnt});
                busy = 1; part = 0; cnt = 0;
            end
        end
    endtask

    task automatic cyc(input bit v, input int p, input bit l, input bit r, input bit c);
        d_valid = v; d_prod = 6'(p); d_last = l; d_ordy = r; d_clr = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Monitor: compares visible state against the model every cycle.
    always @(negedge clk) begin
        chk("in_ready_a", int'(ifa.in_ready), int'(!busy));
        chk("in_ready_b", int'(ifb.in_ready), int'(!busy));
        chk("out_valid_a", int'(ifa.out_valid), int'(busy));
        chk("out_valid_b", int'(ifb.out_valid), int'(busy));
        if (busy && q.size() > 0) begin
            chk("result_a", int'(ifa.acc_out), clip(q[0].total, WA));
            chk("result_sat_a", int'(ifa.sat), int'(q[0].total > clip(q[0].total, WA)));
            chk("result_b", int'(ifb.acc_out), clip(q[0].total, WB));
            chk("result_sat_b", int'(ifb.sat), int'(q[0].total > clip(q[0].total, WB)));
            chk("result_cnt", int'(ifa.term_cnt), q[0].cnt);
            if (d_ordy || d_clr) void'(q.pop_front());
        end else begin
            chk("partial_a", int'(ifa.acc_out), clip(part, WA));
            chk("partial_sat_a", int'(ifa.sat), int'(part > clip(part, WA)));
            chk("partial_b", int'(ifb.acc_out), clip(part, WB));
            chk("partial_sat_b", int'(ifb.sat), int'(part > clip(part, WB)));
            chk("partial_cnt", int'(ifb.term_cnt), cnt);
        end
    end

    initial begin
        #22 rst_n = 1'b1;

        // eight full-length beats of 49
        for (int i = 0; i < 8; i++) cyc(1, 49, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // short group 5,12,0 then held result, extra beats ignored
        cyc(1, 5, 0, 0, 0);
        cyc(1, 12, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 7, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // overflow on the narrow instance, then a clean group
        for (int i = 0; i < 5; i++) cyc(1, 49, 0, 0, 0);
        cyc(1, 49, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 3, 0, 1, 0);
        cyc(1, 4, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // clr collides with a beat
        for (int i = 0; i < 3; i++) cyc(1, 10, 0, 0, 0);
        cyc(1, 20, 0, 0, 1);
        cyc(1, 9, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // asynchronous reset while a result is pending
        cyc(1, 40, 1, 0, 0);
        d_valid = 0; d_last = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_acc", int'(ifa.acc_out), 0);
        chk("async_vld", int'(ifa.out_valid), 0);
        chk("async_cnt", int'(ifa.term_cnt), 0);
        busy = 0; part = 0; cnt = 0; q.delete();
        #3 rst_n = 1'b1;
        #1 chk("rdy_after_rst", int'(ifa.in_ready), 1);

        // randomised traffic with throttling and occasional clr
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 4) != 0, int'($urandom % 64), ($urandom % 5) == 0,
                ($urandom % 3) != 0, ($urandom % 60) == 0);

        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
